fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter VEC_ADDR, default 32'h0000_0000; word address of the reset-vector pair.
REQ-002 SHALL have parameter TWO_WORD_BIT, default 15; the instruction bit that, when 1, marks a two-word instruction (opcode word followed by a 16-bit immediate word).
REQ-003 SHALL have port i_clk, input, 1; the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port i_reset, input, 1; reset, synchronous and active-high.
REQ-005 SHALL have port i_stall, input, 1; hazard stall from the decode stage.
REQ-006 SHALL have port i_branch_taken, input, 1; redirect request.
REQ-007 SHALL have port i_branch_target, input, 32; redirect word address.
REQ-008 SHALL have port o_mem_address, output, 32; instruction memory word address.
REQ-009 SHALL have port o_mem_enable, output, 1; instruction memory read enable.
REQ-010 SHALL have port i_mem_data, input, 16; memory read word, valid by the rising edge that ends the cycle in which its address was presented.
REQ-011 SHALL have port o_instruction, output, 16; opcode word.
REQ-012 SHALL have port o_immediate, output, 16; immediate word, 0 for one-word instructions.
REQ-013 SHALL have port o_pc, output, 32; word address of o_instruction.
REQ-014 SHALL have port o_valid, output, 1; o_instruction, o_immediate and o_pc hold a complete instruction.

Function
REQ-015 SHALL implement states VEC_LO, VEC_HI, FETCH and IMM, with internal 32-bit pc and 16-bit opcode-hold registers.
REQ-016 VEC_LO SHALL read mem[VEC_ADDR] into pc[15:0] and then go to VEC_HI; VEC_HI SHALL read mem[VEC_ADDR+1] into pc[31:16] and then go to FETCH.
REQ-017 VEC_LO and VEC_HI SHALL ignore i_stall and i_branch_taken, and SHALL hold o_valid at 0.
REQ-018 o_mem_address SHALL equal VEC_ADDR in VEC_LO, VEC_ADDR+1 in VEC_HI, and pc in FETCH and IMM.
REQ-019 o_mem_enable SHALL be 1 in VEC_LO and VEC_HI, and SHALL be ~i_stall in FETCH and IMM.
REQ-020 FETCH, no stall, data bit TWO_WORD_BIT=0: o_instruction<=data, o_immediate<=0, o_pc<=pc, o_valid<=1, pc<=pc+1; the state SHALL remain FETCH.
REQ-021 FETCH, no stall, data bit TWO_WORD_BIT=1: hold<=data, o_valid<=0, pc<=pc+1, then go to IMM.
REQ-022 IMM, no stall: o_instruction<=hold, o_immediate<=data, o_pc<=pc-1, o_valid<=1, pc<=pc+1, then go to FETCH.
REQ-023 A one-word instruction SHALL take 1 cycle and a two-word instruction 2 cycles; back-to-back one-word instructions SHALL sustain 1 per cycle.
REQ-024 i_stall=1 with no branch SHALL hold the state, pc, hold register and all registered outputs unchanged.
REQ-025 i_branch_taken=1 in FETCH or IMM SHALL set pc<=i_branch_target, state<=FETCH and o_valid<=0, and SHALL discard any held opcode word.
REQ-026 i_branch_taken SHALL take priority over i_stall.
REQ-027 pc arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFF+1 wraps to 0; all 32 bits SHALL drive o_mem_address with no truncation.
REQ-028 A branch arriving in IMM SHALL drop the partial instruction, and no output SHALL carry the dropped opcode word.

Reset
REQ-029 i_reset=1 SHALL take priority over all other inputs.
REQ-030 On reset: state<=VEC_LO, pc<=0, hold<=0, o_instruction<=0, o_immediate<=0, o_pc<=0, o_valid<=0.
REQ-031 A reset asserted mid-instruction (including in IMM) or mid-vector SHALL restart the vector fetch from VEC_LO on the following cycle.
REQ-032 o_mem_enable SHALL be 0 during any cycle in which i_reset=1.

Structure
REQ-033 The state encoding (2-bit localparams) and the default TWO_WORD_BIT SHALL live in shared package fetch_pkg.
REQ-034 The block SHALL be a single module with no sub-module; it SHALL instantiate neither the instruction memory nor any adder sub-block.

Verification
REQ-035 Reset vector: mem[0]=16'h0020, mem[1]=16'h0000, reset released -> two vector cycles, then o_mem_address=32'h20 and the first o_valid arrives 1 cycle later with o_pc=32'h20.
REQ-036 Mixed stream: mem[0x20]=16'h1234, mem[0x21]=16'h8001, mem[0x22]=16'hBEEF -> o_valid pulses with (1234, 0000, pc 20), then a 1-cycle gap, then (8001, BEEF, pc 21).
REQ-037 Stall: i_stall=1 for 3 cycles while in IMM -> outputs frozen, o_mem_enable=0 for those 3 cycles, and the same immediate is captured after release.
REQ-038 Branch in IMM plus stall: i_branch_taken=1 with target 32'h40 and i_stall=1 in the same cycle -> o_valid=0, the next address is 32'h40, and the held opcode never appears.
REQ-039 Wrap: pc=32'hFFFF_FFFF with a one-word instruction -> the next o_mem_address is 32'h0.
REQ-040 Mid-instruction reset: i_reset=1 while in IMM -> all outputs are 0 on the next cycle, the state is VEC_LO, and o_mem_address=VEC_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and defaults for the instruction fetch controller
package fetch_pkg;

  localparam logic [1:0] ST_VEC_LO = 2'd0;
  localparam logic [1:0] ST_VEC_HI = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_IMM    = 2'd3;

  typedef enum logic [1:0] {
    S_VEC_LO = ST_VEC_LO,
    S_VEC_HI = ST_VEC_HI,
    S_FETCH  = ST_FETCH,
    S_IMM    = ST_IMM
  } fetch_state_e;

  // Opcode bit that flags an instruction followed by a 16-bit immediate word.
  localparam int unsigned TWO_WORD_BIT_DEFAULT = 15;

endpackage

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - reset-vector load and one/two-word instruction fetch FSM
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] VEC_ADDR     = 32'h0000_0000,
  parameter int unsigned TWO_WORD_BIT = TWO_WORD_BIT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_mem_address,
  output logic        o_mem_enable,
  input  logic [15:0] i_mem_data,
  output logic [15:0] o_instruction,
  output logic [15:0] o_immediate,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  hold_q, hold_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  imm_q, imm_d;
  logic [31:0]  opc_q, opc_d;
  logic         valid_q, valid_d;

  // Memory request: vector words at fixed addresses, otherwise the running pc.
  always_comb begin
    o_mem_address = pc_q;
    o_mem_enable  = ~i_stall;
    if (state_q == S_VEC_LO) begin
      o_mem_address = VEC_ADDR;
      o_mem_enable  = 1'b1;
    end else if (state_q == S_VEC_HI) begin
      o_mem_address = VEC_ADDR + 32'd1;
      o_mem_enable  = 1'b1;
    end
    if (i_reset) begin
      o_mem_enable = 1'b0;
    end
  end

  // Next state: vector load, then fetch with branch over stall priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    if (state_q == S_VEC_LO) begin
      pc_d[15:0] = i_mem_data;
      valid_d    = 1'b0;
      state_d    = S_VEC_HI;
    end else if (state_q == S_VEC_HI) begin
      pc_d[31:16] = i_mem_data;
      valid_d     = 1'b0;
      state_d     = S_FETCH;
    end else if (i_branch_taken) begin
      // The word read this cycle and any held opcode belong to the wrong path.
      pc_d    = i_branch_target;
      hold_d  = 16'h0000;
      valid_d = 1'b0;
      state_d = S_FETCH;
    end else if (!i_stall) begin
      pc_d = pc_q + 32'd1;
      if (state_q == S_IMM) begin
        instr_d = hold_q;
        imm_d   = i_mem_data;
        opc_d   = pc_q - 32'd1;
        valid_d = 1'b1;
        state_d = S_FETCH;
      end else if (i_mem_data[TWO_WORD_BIT]) begin
        hold_d  = i_mem_data;
        valid_d = 1'b0;
        state_d = S_IMM;
      end else begin
        instr_d = i_mem_data;
        imm_d   = 16'h0000;
        opc_d   = pc_q;
        valid_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_VEC_LO;
      pc_q    <= 32'h0;
      hold_q  <= 16'h0;
      instr_q <= 16'h0;
      imm_q   <= 16'h0;
      opc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_immediate   = imm_q;
  assign o_pc          = opc_q;
  assign o_valid       = valid_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

  localparam logic [31:0] VEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br;
  logic [31:0] tgt;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_data;
  logic [15:0] ins, imm;
  logic [31:0] opc;
  logic        val;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr[7:0]];

  fetch_controller #(.VEC_ADDR(VEC), .TWO_WORD_BIT(15)) dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_branch_taken(br),
    .i_branch_target(tgt), .o_mem_address(mem_addr), .o_mem_enable(mem_en),
    .i_mem_data(mem_data), .o_instruction(ins), .o_immediate(imm),
    .o_pc(opc), .o_valid(val)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: vec_left counts vector words still to load; have_op marks a
  // buffered opcode awaiting its immediate word.
  int          vec_left = 2;
  bit          known    = 0;
  logic [31:0] m_pc     = '0;
  logic [15:0] m_hold   = '0;
  bit          have_op  = 0;
  logic [15:0] m_ins = '0, m_imm = '0;
  logic [31:0] m_opc = '0;
  bit          m_val = 0;
  logic [31:0] obs_addr;
  logic        obs_en;

  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    logic [31:0] ea;
    logic        ee;
    logic [15:0] d;
    rst = r; stall = s; br = b; tgt = t;
    #1;
    ea = (vec_left == 2) ? VEC : (vec_left == 1) ? VEC + 32'd1 : m_pc;
    ee = r ? 1'b0 : (vec_left > 0) ? 1'b1 : !s;
    obs_addr = mem_addr;
    obs_en   = mem_en;
    if (known) check_eq("mem_address", mem_addr, ea);
    check_eq("mem_enable", {31'b0, mem_en}, {31'b0, ee});
    d = mem[ea[7:0]];
    if (r) begin
      vec_left = 2; m_pc = 0; m_hold = 0; have_op = 0;
      m_ins = 0; m_imm = 0; m_opc = 0; m_val = 0; known = 1;
    end else if (vec_left == 2) begin
      m_pc[15:0] = d; vec_left = 1; m_val = 0;
    end else if (vec_left == 1) begin
      m_pc[31:16] = d; vec_left = 0; m_val = 0;
    end else if (b) begin
      m_pc = t; have_op = 0; m_val = 0;
    end else if (!s) begin
      if (have_op) begin
        m_ins = m_hold; m_imm = d; m_opc = m_pc - 1; m_val = 1; have_op = 0;
      end else if (d[15]) begin
        m_hold = d; have_op = 1; m_val = 0;
      end else begin
        m_ins = d; m_imm = 0; m_opc = m_pc; m_val = 1;
      end
      m_pc = m_pc + 1;
    end
    @(posedge clk);
    #1;
    if (known) begin
      check_eq("valid", {31'b0, val}, {31'b0, m_val});
      check_eq("instruction", {16'b0, ins}, {16'b0, m_ins});
      check_eq("immediate", {16'b0, imm}, {16'b0, m_imm});
      check_eq("pc", opc, m_opc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0020; mem[1] = 16'h0000;
    mem[8'h20] = 16'h1234; mem[8'h21] = 16'h8001; mem[8'h22] = 16'hBEEF;
    mem[8'h23] = 16'h8123; mem[8'h24] = 16'h5555;
    mem[8'h40] = 16'h0042; mem[8'h41] = 16'h9000; mem[8'hFF] = 16'h0007;
    rst = 1; stall = 0; br = 0; tgt = 0;
    @(posedge clk); #1;

    // Reset state and vector load
    step(1, 0, 0, 0);
    check_eq("rst_valid", {31'b0, val}, 32'd0);
    check_eq("rst_pc", opc, 32'd0);
    step(0, 1, 1, 32'h77);
    check_eq("vec_lo_addr", obs_addr, VEC);
    step(0, 1, 0, 0);
    check_eq("vec_hi_addr", obs_addr, VEC + 32'd1);
    check_eq("vec_valid", {31'b0, val}, 32'd0);

    // Mixed one-word / two-word stream
    step(0, 0, 0, 0);
    check_eq("first_addr", obs_addr, 32'h20);
    check_eq("first_valid", {31'b0, val}, 32'd1);
    check_eq("first_ins", {16'b0, ins}, 32'h1234);
    check_eq("first_imm", {16'b0, imm}, 32'h0);
    check_eq("first_pc", opc, 32'h20);
    step(0, 0, 0, 0);
    check_eq("gap_valid", {31'b0, val}, 32'd0);

    // Stall in IMM for three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check_eq("stall_en", {31'b0, obs_en}, 32'd0);
      check_eq("stall_ins", {16'b0, ins}, 32'h1234);
      check_eq("stall_valid", {31'b0, val}, 32'd0);
    end
    step(0, 0, 0, 0);
    check_eq("two_valid", {31'b0, val}, 32'd1);
    check_eq("two_ins", {16'b0, ins}, 32'h8001);
    check_eq("two_imm", {16'b0, imm}, 32'hBEEF);
    check_eq("two_pc", opc, 32'h21);

    // Branch with stall while in IMM
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h40);
    check_eq("br_valid", {31'b0, val}, 32'd0);
    check_eq("br_next_addr", mem_addr, 32'h40);
    step(0, 0, 0, 0);
    check_eq("br_ins", {16'b0, ins}, 32'h0042);
    check_eq("br_pc", opc, 32'h40);
    check_eq("br_imm", {16'b0, imm}, 32'h0);

    // Reset while in IMM
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("midrst_valid", {31'b0, val}, 32'd0);
    check_eq("midrst_ins", {16'b0, ins}, 32'd0);
    check_eq("midrst_imm", {16'b0, imm}, 32'd0);
    check_eq("midrst_pc", opc, 32'd0);
    check_eq("midrst_addr", mem_addr, VEC);

    // pc wrap at the top of the address space
    mem[0] = 16'hFFFF; mem[1] = 16'hFFFF;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("wrap_start", mem_addr, 32'hFFFF_FFFF);
    step(0, 0, 0, 0);
    check_eq("wrap_ins", {16'b0, ins}, 32'h0007);
    check_eq("wrap_pc", opc, 32'hFFFF_FFFF);
    check_eq("wrap_next", mem_addr, 32'h0);

    // Randomized traffic against the reference
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) == 0, ($urandom % 100) < 30,
           ($urandom % 100) < 8, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
